// File: rtl/ram_master_lsu.sv
// Load/store master for a byte-selectable, big-endian data RAM.
// Takes one request at a time, drives the RAM port for a single cycle, and
// returns an aligned, extended load result with a one-cycle response pulse.
// Misaligned or illegal requests are answered with an error and never
// reach the RAM.
//
// Request handshake: a request is accepted on a rising edge where
// req_valid_i and req_ready_o are both high. req_ready_o is high only in
// IDLE, and req_valid_i is ignored in every other state. The response side
// has no backpressure: resp_valid_o is a single-cycle pulse.
//
// Per-request cycle counts, acceptance cycle included:
//   store: IDLE, ISSUE, RESP        (3 cycles)
//   load:  IDLE, ISSUE, WAIT, RESP  (4 cycles)
//   error: IDLE, RESP               (2 cycles)
module ram_master_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic        w_accept;
  logic        w_misalign;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_rev;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  assign req_ready_o = (r_state == S_IDLE);
  assign dbg_state_o = r_state;
  assign w_accept    = req_valid_i && req_ready_o;

  // Alignment check and store lane/data formation from the incoming request
  always_comb begin
    w_misalign = 1'b0;
    w_sel      = 4'b0000;
    w_wdata    = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        w_sel   = 4'b1000 >> req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_misalign = req_addr_i[0];
        w_sel      = req_addr_i[1] ? 4'b0011 : 4'b1100;
        w_wdata    = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        w_misalign = (req_addr_i[1:0] != 2'b00);
        w_sel      = 4'b1111;
      end
      default: w_misalign = 1'b1;
    endcase
  end

  // Read extraction: undo the RAM's lane reversal, then shift the addressed
  // byte/half to the top so it can be picked from fixed bits and extended
  always_comb begin
    w_rev   = {ram_data_i[7:0], ram_data_i[15:8], ram_data_i[23:16], ram_data_i[31:24]};
    w_shift = w_rev << {r_off, 3'b000};
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_shift[31]}}, w_shift[31:24]};
      2'b01:   w_ext = {{16{r_signed & w_shift[31]}}, w_shift[31:16]};
      default: w_ext = w_rev;
    endcase
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_misalign ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Registered outputs and latched request attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      ram_ce_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_sel_o    <= 4'b0000;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      ram_ce_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we_i;
            r_size   <= req_size_i;
            r_signed <= req_signed_i;
            r_off    <= req_addr_i[1:0];
            if (w_misalign) begin
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              ram_ce_o   <= 1'b1;
              ram_we_o   <= req_we_i;
              ram_sel_o  <= w_sel;
              ram_addr_o <= req_addr_i;
              ram_data_o <= w_wdata;
            end
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
          end
        end
        S_WAIT: begin
          resp_valid_o <= 1'b1;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= w_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master_lsu.sv
// Testbench for ram_master_lsu: directed cases plus randomized loads/stores
// compared against a byte-addressed big-endian memory model.
module tb_ram_master_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int ce_count = 0;

  logic [7:0]  ram_bytes[0:255];
  logic [7:0]  ref_bytes[0:255];
  logic [31:0] exp_q[$];

  ram_master_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset-free clock generator
  always #5 clk = ~clk;

  // RAM model: byte k of a word sits on write lane sel[3-k] / bits [31-8k -: 8]
  // and is returned on read bits [8k +: 8] one cycle after the read is sampled
  always @(posedge clk) begin
    if (ram_ce) begin
      ce_count++;
      if (ram_we) begin
        for (int k = 0; k < 4; k++)
          if (ram_sel[3-k]) ram_bytes[{ram_addr[7:2], 2'(k)}] = ram_wdata[31-8*k -: 8];
      end else begin
        for (int k = 0; k < 4; k++)
          ram_rdata[8*k +: 8] <= ram_bytes[{ram_addr[7:2], 2'(k)}];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: plain byte-array memory, big-endian multi-byte values
  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int n;
    if (sz == 2'd3) return 1'b1;
    n = 1 << sz;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[a[7:0] + 8'(i)]);
    if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_bytes[a[7:0] + 8'(i)] = wd[8*(n-1-i) +: 8];
  endtask

  // driver: present one request, wait for its response, report latency
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata;
    er = resp_err;
  endtask

  // one request fully checked against the reference model
  task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic        mis, er;
    logic [31:0] exp_rd, exp_sel, exp_dat;
    int          lat, ce0;
    mis    = ref_misaligned(sz, a);
    exp_rd = (we || mis) ? 32'h0 : ref_load(sz, sg, a);
    ce0    = ce_count;
    do_req(we, sz, sg, a, wd, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), mis ? 32'd0 : (we ? 32'd1 : 32'd2));
    check({tag, "_err"}, 32'(er), 32'(mis));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_ce_pulses"}, 32'(ce_count - ce0), mis ? 32'd0 : 32'd1);
    if (we && !mis) begin
      exp_sel = 0;
      for (int i = 0; i < (1 << sz); i++) exp_sel[3 - (a[1:0] + i)] = 1'b1;
      exp_dat = (sz == 0) ? {4{wd[7:0]}} : (sz == 1) ? {2{wd[15:0]}} : wd;
      check({tag, "_sel"}, 32'(ram_sel), exp_sel);
      check({tag, "_wdata"}, ram_wdata, exp_dat);
      check({tag, "_addr"}, ram_addr, a);
      ref_store(sz, a, wd);
    end
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_outs"}, {24'd0, resp_valid, resp_err, ram_ce, ram_we, ram_sel}, 32'd0);
    check({tag, "_addr"}, ram_addr, 32'd0);
    check({tag, "_wdata"}, ram_wdata, 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] q_addr[3];
    logic [1:0]  q_size[3];
    logic        q_sg[3];
    int          acc_cyc[3];
    int          acc, nresp, cyc, ce0, pulses;
    logic        acc_now;

    for (int i = 0; i < 256; i++) begin
      rd = $urandom;
      ram_bytes[i] = rd[7:0];
      ref_bytes[i] = rd[7:0];
    end
    ram_rdata = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 0;
    req_signed = 1'b0; req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // directed cases
    do_op("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd);
    do_op("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check("ld_w10_const", rd, 32'h11223344);
    do_op("ld_sb11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd);
    check("ld_sb11_const", rd, 32'h00000022);
    do_op("ld_sh12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd);
    check("ld_sh12_const", rd, 32'h00003344);
    do_op("st_b13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, rd);
    check("st_b13_sel", 32'(ram_sel), 32'h1);
    check("st_b13_data", ram_wdata, 32'h80808080);
    do_op("ld_sb13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd);
    check("ld_sb13_const", rd, 32'hFFFFFF80);
    do_op("ld_ub13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd);
    check("ld_ub13_const", rd, 32'h00000080);
    do_op("ld_w10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check("ld_w10b_const", rd, 32'h11223380);
    do_op("err_h21", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, rd);
    do_op("err_w22", 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, rd);
    do_op("err_sz3", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, rd);
    do_op("st_h16", 1'b1, 2'd1, 1'b0, 32'h16, 32'hABCD8001, rd);
    do_op("ld_sh16", 1'b0, 2'd1, 1'b1, 32'h16, 32'h0, rd);

    // reset during WAIT of a load
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_wait", 32'(dbg_state), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) pulses++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) pulses++; end
    check("midrst_no_resp", 32'(pulses), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    do_op("ld_w10_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check("ld_w10_after_rst_const", rd, 32'h11223380);

    // three loads queued with valid held high
    q_addr = '{32'h10, 32'h11, 32'h12};
    q_size = '{2'd2, 2'd0, 2'd1};
    q_sg   = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    req_we = 1'b0; req_size = q_size[0]; req_signed = q_sg[0]; req_addr = q_addr[0];
    req_valid = 1'b1;
    acc = 0; nresp = 0; cyc = 0; ce0 = ce_count;
    while (nresp < 3 && cyc < 40) begin
      acc_now = req_ready && req_valid;
      @(posedge clk); #1; cyc++;
      if (acc_now) begin
        acc_cyc[acc] = cyc;
        exp_q.push_back(ref_load(q_size[acc], q_sg[acc], q_addr[acc]));
        acc++;
        if (acc < 3) begin
          req_size = q_size[acc]; req_signed = q_sg[acc]; req_addr = q_addr[acc];
        end else req_valid = 1'b0;
      end
      if (resp_valid) begin
        nresp++;
        if (exp_q.size() > 0) check("queued_rdata", resp_rdata, exp_q.pop_front());
        else check("queued_unexpected_resp", 32'd1, 32'd0);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("queued_accepts", 32'(acc), 32'd3);
    check("queued_resps", 32'(nresp), 32'd3);
    check("queued_ce_pulses", 32'(ce_count - ce0), 32'd3);
    if (acc == 3) begin
      check("queued_gap1_ge3", 32'(acc_cyc[1] - acc_cyc[0] >= 3), 32'd1);
      check("queued_gap2_ge3", 32'(acc_cyc[2] - acc_cyc[1] >= 3), 32'd1);
    end

    // randomized loads/stores in 0x40..0x7F
    for (int i = 0; i < 40; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 32'($urandom_range(64, 127)), $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
